seg7_display_reader: RTL and testbench
======================================

Name: seg7_display_reader

Overview:
- Receiver/decoder for the multiplexed seven-segment display bus driven by the ALU display path.
- Samples the segment lines and one-hot digit enables, and waits for each digit's pattern to be stable.
- Decodes each stable pattern back to a hex nibble and assembles a full multi-digit frame.
- Used in simulation and on-chip self-check to read back what the display shows, with an error flag for each kind of bus fault.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (inputs are inverted before decoding).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines {g,f,e,d,c,b,a}.
- dig_en  input  NUM_DIGITS  digit enables, active-high, expected one-hot or zero.
- frame_valid  output  1  one-cycle pulse: every digit captured since the last frame.
- frame_data  output  4*NUM_DIGITS  decoded nibbles; digit i in bits [4i+3:4i].
- blank_mask  output  NUM_DIGITS  bit i = digit i was captured blank (all segments off).
- err_invalid  output  1  one-cycle pulse: a captured pattern is neither a hex glyph nor blank.
- err_onehot  output  1  one-cycle pulse: dig_en had more than one bit set.

Behaviour:
- Reset (async, active-high) forces the following, held while rst=1:
  - all outputs 0;
  - FSM in WAIT;
  - stability counter 0;
  - captured mask 0;
  - digit registers 0.
- Sampling and normalisation:
  - seg_in and dig_en are sampled on every rising edge.
  - Normalised pattern p = SEG_ACTIVE_LOW ? ~seg_in : seg_in.
- Glyph table (p, active-high, gfedcba → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7;
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F;
  - 00→blank (nibble 0, blank bit set);
  - any other value → invalid.
- FSM WAIT:
  - dig_en==0 → stay in WAIT, counter 0.
  - dig_en one-hot → go to DWELL, counter=1, latch pattern and select.
  - dig_en non-one-hot → pulse err_onehot, stay in WAIT.
- FSM DWELL:
  - Same select and pattern as latched → counter+1.
  - On the sample where counter reaches STABLE_CYCLES, capture and go to HELD.
  - Select or pattern changes to another valid one-hot → restart DWELL with counter=1.
  - Select changes to zero → go to WAIT.
  - Select changes to non-one-hot → pulse err_onehot and go to WAIT.
- FSM HELD:
  - Same select and pattern → stay; no recapture.
  - Any change → handled exactly as from WAIT.
- Capture edge (all on the same edge):
  - Write digit register i and blank_mask[i].
  - Set captured mask bit i.
  - Invalid pattern: pulse err_invalid; digit register and mask are NOT updated.
- Latency: capture occurs on the STABLE_CYCLES-th consecutive identical sample edge.
- Recapture of an already-captured digit within the same frame overwrites its value.
- Frame completion:
  - When the capture edge makes the mask all-ones, frame_valid=1 for the following cycle.
  - frame_data and blank_mask are updated on that same edge and hold until the next frame.
  - The mask clears on that edge.
- A pattern change of one sample restarts the count (glitch rejection); no partial capture.
- Reset mid-frame discards the partial frame; the previous frame_data clears to 0.

Decomposition:
- Package seg7_pkg:
  - glyph constants SEG_0..SEG_F and SEG_BLANK, as 7-bit logic;
  - FSM enum state_t {WAIT, DWELL, HELD};
  - type seg_t = logic [6:0].
- Sub-module seg7_to_hex (combinational):
  - input p[6:0];
  - outputs nibble[3:0], is_blank, is_invalid;
  - shares the glyph table with the display encoder.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4, SEG_ACTIVE_LOW=1):
- Scan digits 0..3 with active-low patterns of A,3,C,1, each held 6 cycles → one frame_valid pulse; frame_data=16'h1C3A; blank_mask=0; no errors.
- Digit 0 shows 5 (~6D) for 3 cycles, glitches 1 cycle, then 5 for 4 cycles → captured only after the second run of 4; no frame_valid until digits 1..3 are also captured.
- Digit 2 held at pattern p=7'h49 for 4 cycles → err_invalid pulses once; captured mask bit 2 stays 0; no frame completes until a valid pattern is captured on digit 2.
- dig_en=4'b0110 for 1 cycle during a scan → err_onehot pulses one cycle; FSM to WAIT; next one-hot digit needs a full 4-sample dwell.
- Digit 3 all segments off (seg_in=7'h7F) with digits 0..2 = 9,4,D → frame_data=16'h0D49 (digit 3 nibble 0); blank_mask=4'b1000.
- Assert rst after 2 of 4 digits are captured → all outputs 0 immediately (async); the following full scan of 0,1,2,3 yields frame_data=16'h3210 with a single frame_valid.

Source files
------------

// File: rtl/seg7_display_reader_pkg.sv
// seg7_pkg: glyph table shared by the display encoder and reader, the FSM
// state type and a one-hot helper.
package seg7_pkg;

    typedef logic [6:0] seg_t;   // {g,f,e,d,c,b,a}, active-high

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {WAIT, DWELL, HELD} state_t;

    // Digit enables are zero-extended to 8 bits (NUM_DIGITS <= 8).
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_display_reader_if.sv
// Display bus plus read-back results.
//   master: display side, drives seg_in/dig_en, observes the results.
//   slave : reader, samples seg_in/dig_en, drives frame/error outputs.
interface seg7_display_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_valid;
    logic [4*NUM_DIGITS-1:0] frame_data;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    err_invalid;
    logic                    err_onehot;

    modport master (
        output seg_in, dig_en,
        input  frame_valid, frame_data, blank_mask, err_invalid, err_onehot
    );

    modport slave (
        input  seg_in, dig_en,
        output frame_valid, frame_data, blank_mask, err_invalid, err_onehot
    );
endinterface

// File: rtl/seg7_display_reader_to_hex.sv
// seg7_to_hex: combinational glyph decoder.
//   i_p          active-high pattern {g,f,e,d,c,b,a}
//   o_nibble     hex value (0 for blank/invalid)
//   o_is_blank   all segments off
//   o_is_invalid neither a hex glyph nor blank
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg_t       i_p,
    output logic [3:0] o_nibble,
    output logic       o_is_blank,
    output logic       o_is_invalid
);
    always_comb begin
        o_nibble     = 4'h0;
        o_is_blank   = 1'b0;
        o_is_invalid = 1'b0;
        case (i_p)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: o_is_blank = 1'b1;
            default:   o_is_invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg7_display_reader.sv
// seg7_display_reader: reads back a multiplexed seven-segment display.
// Each digit's (select, pattern) must be seen unchanged for STABLE_CYCLES
// consecutive samples before it is decoded and captured; once every digit
// has been captured a frame is published.
//   clk, rst       clock, async active-high reset
//   bus (slave)    seg_in/dig_en in; frame_valid, frame_data, blank_mask,
//                  err_invalid, err_onehot out (all registered)
module seg7_display_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_display_reader_if.slave  bus
);
    state_t                      r_state;
    logic [7:0]                  r_cnt;
    logic [NUM_DIGITS-1:0]       r_sel;
    seg_t                        r_pat;
    logic [NUM_DIGITS-1:0]       r_mask;
    logic [NUM_DIGITS-1:0][3:0]  r_digits;
    logic [NUM_DIGITS-1:0]       r_blanks;
    logic                        r_frame_valid;
    logic [4*NUM_DIGITS-1:0]     r_frame_data;
    logic [NUM_DIGITS-1:0]       r_blank_mask;
    logic                        r_err_invalid;
    logic                        r_err_onehot;

    logic [NUM_DIGITS-1:0]       w_sel;
    logic [7:0]                  w_sel8;
    seg_t                        w_pat;
    logic                        w_zero;
    logic                        w_onehot;
    logic                        w_same;
    logic                        w_capture;
    logic                        w_frame_done;
    logic [NUM_DIGITS-1:0]       w_mask_nx;
    logic [NUM_DIGITS-1:0][3:0]  w_digits_nx;
    logic [NUM_DIGITS-1:0]       w_blanks_nx;
    logic [3:0]                  w_nibble;
    logic                        w_is_blank;
    logic                        w_is_invalid;

    assign w_sel = bus.dig_en;
    assign w_pat = (SEG_ACTIVE_LOW != 0) ? ~bus.seg_in : bus.seg_in;

    always_comb begin
        w_sel8 = 8'd0;
        w_sel8[NUM_DIGITS-1:0] = w_sel;
    end

    assign w_zero   = (w_sel == '0);
    assign w_onehot = is_onehot8(w_sel8);
    assign w_same   = (w_sel == r_sel) && (w_pat == r_pat);

    // Capture fires on the sample that brings the run to STABLE_CYCLES.
    assign w_capture = (r_state == DWELL) && w_same &&
                       (r_cnt == 8'(STABLE_CYCLES - 1));

    seg7_to_hex u_dec (
        .i_p          (w_pat),
        .o_nibble     (w_nibble),
        .o_is_blank   (w_is_blank),
        .o_is_invalid (w_is_invalid)
    );

    // Digit/blank registers as they will be after this capture, so a
    // completing capture publishes its own digit in the same edge.
    always_comb begin
        w_digits_nx = r_digits;
        w_blanks_nx = r_blanks;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_digits_nx[i] = w_nibble;
                w_blanks_nx[i] = w_is_blank;
            end
        end
    end

    assign w_mask_nx    = r_mask | w_sel;
    assign w_frame_done = w_capture && !w_is_invalid && (&w_mask_nx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= WAIT;
            r_cnt         <= 8'd0;
            r_sel         <= '0;
            r_pat         <= '0;
            r_mask        <= '0;
            r_digits      <= '0;
            r_blanks      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_blank_mask  <= '0;
            r_err_invalid <= 1'b0;
            r_err_onehot  <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_err_invalid <= 1'b0;
            r_err_onehot  <= 1'b0;

            // WAIT always re-evaluates; DWELL/HELD only when the sample moves.
            if (r_state != WAIT && w_same) begin
                if (r_state == DWELL) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_capture)
                        r_state <= HELD;
                end
            end else if (w_zero) begin
                r_state <= WAIT;
                r_cnt   <= 8'd0;
            end else if (!w_onehot) begin
                r_state      <= WAIT;
                r_cnt        <= 8'd0;
                r_err_onehot <= 1'b1;
            end else begin
                r_state <= DWELL;
                r_cnt   <= 8'd1;
                r_sel   <= w_sel;
                r_pat   <= w_pat;
            end

            if (w_capture) begin
                if (w_is_invalid) begin
                    r_err_invalid <= 1'b1;
                end else begin
                    r_digits <= w_digits_nx;
                    r_blanks <= w_blanks_nx;
                    if (w_frame_done) begin
                        r_mask        <= '0;
                        r_frame_valid <= 1'b1;
                        r_frame_data  <= w_digits_nx;
                        r_blank_mask  <= w_blanks_nx;
                    end else begin
                        r_mask <= w_mask_nx;
                    end
                end
            end
        end
    end

    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_data  = r_frame_data;
    assign bus.blank_mask  = r_blank_mask;
    assign bus.err_invalid = r_err_invalid;
    assign bus.err_onehot  = r_err_onehot;

endmodule

// File: tb/tb_seg7_display_reader.sv
// Bench for seg7_display_reader (4 digits, 4-sample dwell, active-low).
// The reference model tracks run lengths of identical one-hot samples and
// a per-frame capture set; every cycle its expected outputs are compared
// with the DUT and divergences are counted for the scenario checks.
module tb_seg7_display_reader;
    localparam int ND = 4;
    localparam int SC = 4;
    localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_display_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg7_display_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int          m_run;
    logic [3:0]  m_sel;
    logic [6:0]  m_pat;
    logic [3:0]  m_mask;
    logic [15:0] m_dig;
    logic [3:0]  m_blk;
    logic        e_fv, e_inv, e_oh;
    logic [15:0] e_fd;
    logic [3:0]  e_bm;
    // event counters: observed (n_) vs model (x_), and cycle divergences
    int n_fv, n_inv, n_oh, x_fv, x_inv, x_oh, div;

    task automatic model_reset();
        m_run = 0; m_sel = 0; m_pat = 0; m_mask = 0; m_dig = 0; m_blk = 0;
        e_fv = 0; e_inv = 0; e_oh = 0; e_fd = 0; e_bm = 0;
    endtask

    task automatic clr();
        n_fv = 0; n_inv = 0; n_oh = 0; x_fv = 0; x_inv = 0; x_oh = 0; div = 0;
    endtask

    task automatic model_step(input logic [3:0] sel, input logic [6:0] p);
        int  idx, nib;
        bit  invalid, blank;
        e_fv = 0; e_inv = 0; e_oh = 0;
        if (sel == 0) begin
            m_run = 0;
        end else if ($countones(sel) != 1) begin
            m_run = 0;
            e_oh  = 1;
        end else begin
            if (m_run > 0 && sel == m_sel && p == m_pat) m_run++;
            else m_run = 1;
            m_sel = sel;
            m_pat = p;
            if (m_run == SC) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
                invalid = 1; blank = 0; nib = 0;
                if (p == 7'h00) begin invalid = 0; blank = 1; end
                for (int v = 0; v < 16; v++) if (GLY[v] == p) begin invalid = 0; nib = v; end
                if (invalid) begin
                    e_inv = 1;
                end else begin
                    m_dig[4*idx +: 4] = 4'(nib);
                    m_blk[idx]  = blank;
                    m_mask[idx] = 1'b1;
                    if (m_mask == 4'hF) begin
                        e_fv = 1; e_fd = m_dig; e_bm = m_blk; m_mask = 0;
                    end
                end
            end
        end
    endtask

    // One sample: drive, clock, advance model, observe #1 after the edge.
    task automatic cyc(input logic [3:0] sel, input logic [6:0] p);
        bus.dig_en = sel;
        bus.seg_in = ~p;
        @(posedge clk);
        model_step(sel, p);
        #1;
        if (bus.frame_valid === 1'b1) n_fv++;
        if (bus.err_invalid === 1'b1) n_inv++;
        if (bus.err_onehot  === 1'b1) n_oh++;
        x_fv += int'(e_fv); x_inv += int'(e_inv); x_oh += int'(e_oh);
        if ({bus.frame_valid, bus.frame_data, bus.blank_mask, bus.err_invalid, bus.err_onehot}
            !== {e_fv, e_fd, e_bm, e_inv, e_oh}) div++;
    endtask

    task automatic hold(input int d, input logic [6:0] p, input int n);
        repeat (n) cyc(4'(1 << d), p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dig_en = '0;
        bus.seg_in = 7'h7F;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.dig_en = '0;
        bus.seg_in = 7'h7F;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b want=0", bus.frame_valid); end
        total++; if (bus.frame_data !== 16'h0) begin bad++; $display("FAIL rst_fd got=%h want=0000", bus.frame_data); end
        total++; if (bus.blank_mask !== 4'h0) begin bad++; $display("FAIL rst_bm got=%b want=0000", bus.blank_mask); end
        total++; if (bus.err_invalid !== 1'b0) begin bad++; $display("FAIL rst_inv got=%b want=0", bus.err_invalid); end
        total++; if (bus.err_onehot !== 1'b0) begin bad++; $display("FAIL rst_oh got=%b want=0", bus.err_onehot); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        do_reset(); clr();
        hold(0, GLY[4'hA], 6); hold(1, GLY[3], 6); hold(2, GLY[4'hC], 6); hold(3, GLY[1], 6);
        total++; if (n_fv !== 1) begin bad++; $display("FAIL scan_fv_count got=%0d want=1", n_fv); end
        total++; if (bus.frame_data !== 16'h1C3A) begin bad++; $display("FAIL scan_fd got=%h want=1c3a", bus.frame_data); end
        total++; if (bus.blank_mask !== 4'h0) begin bad++; $display("FAIL scan_bm got=%b want=0000", bus.blank_mask); end
        total++; if (n_inv + n_oh !== 0) begin bad++; $display("FAIL scan_errs got=%0d want=0", n_inv + n_oh); end
        total++; if (div !== 0) begin bad++; $display("FAIL scan_model got=%0d diverging cycles want=0", div); end
    endtask

    task automatic test_glitch();
        do_reset(); clr();
        hold(0, GLY[5], 3); hold(0, GLY[6], 1); hold(0, GLY[5], 4);
        hold(1, GLY[7], 4); hold(2, GLY[8], 4); hold(3, GLY[2], 3);
        total++; if (n_fv !== 0) begin bad++; $display("FAIL glitch_early_fv got=%0d want=0", n_fv); end
        hold(3, GLY[2], 1);
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL glitch_latency got=%b want=1", bus.frame_valid); end
        total++; if (bus.frame_data !== 16'h2875) begin bad++; $display("FAIL glitch_fd got=%h want=2875", bus.frame_data); end
        total++; if (div !== 0) begin bad++; $display("FAIL glitch_model got=%0d diverging cycles want=0", div); end
    endtask

    task automatic test_invalid();
        do_reset(); clr();
        hold(2, 7'h49, 4);
        total++; if (bus.err_invalid !== 1'b1) begin bad++; $display("FAIL inv_pulse got=%b want=1", bus.err_invalid); end
        hold(2, 7'h49, 3);
        hold(0, GLY[1], 4); hold(1, GLY[2], 4); hold(3, GLY[4], 4);
        total++; if (n_inv !== 1 || n_fv !== 0) begin bad++; $display("FAIL inv_no_frame got inv=%0d fv=%0d want inv=1 fv=0", n_inv, n_fv); end
        hold(2, GLY[3], 4);
        total++; if (n_fv !== 1 || bus.frame_data !== 16'h4321) begin bad++; $display("FAIL inv_recover got fv=%0d fd=%h want fv=1 fd=4321", n_fv, bus.frame_data); end
        total++; if (div !== 0) begin bad++; $display("FAIL inv_model got=%0d diverging cycles want=0", div); end
    endtask

    task automatic test_onehot();
        do_reset(); clr();
        hold(0, GLY[6], 4); hold(1, GLY[7], 2);
        cyc(4'b0110, GLY[7]);
        total++; if (bus.err_onehot !== 1'b1) begin bad++; $display("FAIL oh_pulse got=%b want=1", bus.err_onehot); end
        hold(1, GLY[7], 3); cyc(4'b0000, 7'h00);
        hold(2, GLY[8], 3); cyc(4'b0000, 7'h00);
        hold(3, GLY[9], 6);
        total++; if (n_fv !== 0) begin bad++; $display("FAIL oh_short_dwell got fv=%0d want=0", n_fv); end
        hold(1, GLY[7], 4); hold(2, GLY[8], 4);
        total++; if (n_fv !== 1 || n_oh !== 1 || bus.frame_data !== 16'h9876) begin
            bad++; $display("FAIL oh_frame got fv=%0d oh=%0d fd=%h want fv=1 oh=1 fd=9876", n_fv, n_oh, bus.frame_data); end
        total++; if (div !== 0) begin bad++; $display("FAIL oh_model got=%0d diverging cycles want=0", div); end
    endtask

    task automatic test_blank();
        do_reset(); clr();
        hold(0, GLY[9], 5); hold(1, GLY[4], 5); hold(2, GLY[4'hD], 5);
        bus.dig_en = 4'b1000; bus.seg_in = 7'h7F;   // raw active-low: all off
        repeat (4) cyc(4'b1000, 7'h00);
        total++; if (bus.frame_data !== 16'h0D49) begin bad++; $display("FAIL blank_fd got=%h want=0d49", bus.frame_data); end
        total++; if (bus.blank_mask !== 4'b1000) begin bad++; $display("FAIL blank_bm got=%b want=1000", bus.blank_mask); end
        total++; if (div !== 0) begin bad++; $display("FAIL blank_model got=%0d diverging cycles want=0", div); end
    endtask

    task automatic test_reset_mid();
        do_reset(); clr();
        hold(0, GLY[1], 4); hold(1, GLY[2], 4); hold(2, GLY[3], 4); hold(3, GLY[4], 4);
        hold(0, GLY[5], 4); hold(1, GLY[6], 4);
        total++; if (bus.frame_data !== 16'h4321) begin bad++; $display("FAIL midrst_before got=%h want=4321", bus.frame_data); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.frame_valid, bus.frame_data, bus.blank_mask, bus.err_invalid, bus.err_onehot} !== 23'h0) begin
            bad++; $display("FAIL midrst_async got fd=%h fv=%b want all zero", bus.frame_data, bus.frame_valid); end
        model_reset();
        bus.dig_en = '0;
        @(posedge clk); #1 rst = 1'b0;
        clr();
        hold(0, GLY[0], 4); hold(1, GLY[1], 4); hold(2, GLY[2], 4); hold(3, GLY[3], 4); hold(3, GLY[3], 2);
        total++; if (n_fv !== 1 || bus.frame_data !== 16'h3210) begin
            bad++; $display("FAIL midrst_scan got fv=%0d fd=%h want fv=1 fd=3210", n_fv, bus.frame_data); end
        total++; if (div !== 0) begin bad++; $display("FAIL midrst_model got=%0d diverging cycles want=0", div); end
    endtask

    task automatic test_random();
        int k, n, d;
        logic [6:0] p;
        logic [3:0] s;
        do_reset(); clr();
        for (int t = 0; t < 400; t++) begin
            k = int'($urandom_range(0, 99));
            if (k < 70) begin
                d = int'($urandom_range(0, ND - 1));
                p = ($urandom_range(0, 9) == 0) ? 7'h00 : GLY[$urandom_range(0, 15)];
                n = int'($urandom_range(1, 7));
                hold(d, p, n);
            end else if (k < 80) begin
                repeat ($urandom_range(1, 2)) cyc(4'b0000, 7'(($urandom)));
            end else if (k < 90) begin
                d = int'($urandom_range(0, ND - 1));
                hold(d, 7'h49, int'($urandom_range(3, 5)));
            end else begin
                s = 4'($urandom);
                while ($countones(s) < 2) s = 4'($urandom);
                cyc(s, GLY[$urandom_range(0, 15)]);
            end
        end
        total++; if (div !== 0) begin bad++; $display("FAIL rand_model got=%0d diverging cycles want=0", div); end
        total++; if (n_fv !== x_fv) begin bad++; $display("FAIL rand_frames got=%0d want=%0d", n_fv, x_fv); end
        total++; if (n_inv !== x_inv) begin bad++; $display("FAIL rand_invalid got=%0d want=%0d", n_inv, x_inv); end
        total++; if (n_oh !== x_oh) begin bad++; $display("FAIL rand_onehot got=%0d want=%0d", n_oh, x_oh); end
        total++; if (bus.frame_data !== e_fd) begin bad++; $display("FAIL rand_fd got=%h want=%h", bus.frame_data, e_fd); end
    endtask

    initial begin
        bus.dig_en = '0;
        bus.seg_in = 7'h7F;
        test_reset();
        test_scan();
        test_glitch();
        test_invalid();
        test_onehot();
        test_blank();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog");
    end

endmodule
